// File: rtl/mul_issue_ctrl_if.sv
// Request (execute -> controller) and response (controller -> writeback) handshakes
// of the multiply issue controller. Signal suffixes are relative to the controller.
interface mul_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [2:0]       in_funct3_i;
    logic [31:0]      in_op_a_i;
    logic [31:0]      in_op_b_i;
    logic [TAG_W-1:0] in_tag_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      out_result_o;
    logic [TAG_W-1:0] out_tag_o;
    logic             out_err_o;

    modport slave (
        input  in_valid_i, in_funct3_i, in_op_a_i, in_op_b_i, in_tag_i,
        output in_ready_o,
        output out_valid_o, out_result_o, out_tag_o, out_err_o,
        input  out_ready_i
    );

    modport master (
        output in_valid_i, in_funct3_i, in_op_a_i, in_op_b_i, in_tag_i,
        input  in_ready_o,
        input  out_valid_o, out_result_o, out_tag_o, out_err_o,
        output out_ready_i
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue controller in front of the RV32M multiplier: decodes funct3, launches the
// multiplier with a one-cycle pulse, returns tagged results; handles bypass, errors, flush.
module mul_issue_ctrl #(
    parameter int TAG_W       = 5,
    parameter int ZERO_BYPASS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mul_issue_ctrl_if.slave io,
    input  logic            flush_i,
    output logic            mult_en_o,
    output logic [31:0]     mult_op_a_o,
    output logic [31:0]     mult_op_b_o,
    output logic            mult_signed_a_o,
    output logic            mult_signed_b_o,
    output logic            mult_upper_o,
    input  logic [31:0]     mult_result_i,
    input  logic            mult_done_i,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic             sgn_a_q, sgn_a_d;
    logic             sgn_b_q, sgn_b_d;
    logic             upper_q, upper_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_q, res_d;
    logic             err_q, err_d;
    logic             vld_q, vld_d;
    logic             en_q, en_d;

    logic             accept;
    logic             req_err;
    logic             req_zero;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sgn_a_d  = sgn_a_q;
        sgn_b_d  = sgn_b_q;
        upper_d  = upper_q;
        tag_d    = tag_q;
        res_d    = res_q;
        err_d    = err_q;
        vld_d    = vld_q;
        en_d     = 1'b0;

        accept   = io.in_valid_i && (state_q == S_IDLE) && !flush_i;
        req_err  = io.in_funct3_i[2];
        req_zero = (ZERO_BYPASS != 0) &&
                   ((io.in_op_a_i == 32'd0) || (io.in_op_b_i == 32'd0));

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_a_d  = io.in_op_a_i;
                    op_b_d  = io.in_op_b_i;
                    tag_d   = io.in_tag_i;
                    // funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
                    sgn_a_d = (io.in_funct3_i[1:0] == 2'b01) || (io.in_funct3_i[1:0] == 2'b10);
                    sgn_b_d = (io.in_funct3_i[1:0] == 2'b01);
                    upper_d = (io.in_funct3_i[1:0] != 2'b00);
                    if (req_err) begin
                        res_d   = 32'd0;
                        err_d   = 1'b1;
                        vld_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (req_zero) begin
                        res_d   = 32'd0;
                        err_d   = 1'b0;
                        vld_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        en_d    = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                // The multiplier is already launched, so a flush must still wait for done.
                state_d = flush_i ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (mult_done_i) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        res_d   = mult_result_i;
                        vld_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mult_done_i) state_d = S_IDLE;
            end
            S_RESP: begin
                if (flush_i || io.out_ready_i) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            upper_q <= 1'b0;
            tag_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sgn_a_q <= sgn_a_d;
            sgn_b_q <= sgn_b_d;
            upper_q <= upper_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            en_q    <= en_d;
        end
    end

    assign io.in_ready_o   = (state_q == S_IDLE);
    assign io.out_valid_o  = vld_q;
    assign io.out_result_o = res_q;
    assign io.out_tag_o    = tag_q;
    assign io.out_err_o    = err_q;

    assign mult_en_o       = en_q;
    assign mult_op_a_o     = op_a_q;
    assign mult_op_b_o     = op_b_q;
    assign mult_signed_a_o = sgn_a_q;
    assign mult_signed_b_o = sgn_b_q;
    assign mult_upper_o    = upper_q;
    assign busy_o          = (state_q != S_IDLE);

    a_en_single: assert property (@(posedge clk_i) disable iff (rst_i) mult_en_o |=> !mult_en_o);
    a_vld_resp:  assert property (@(posedge clk_i) disable iff (rst_i) vld_q |-> (state_q == S_RESP));

endmodule
